nebula_commit_collector: RTL and testbench
==========================================

// Module: nebula_commit_collector
// PURPOSE
// Return path from the nebula cores back to the IFE. The dispatcher registers each
// issued block (ID plus target-core mask) here. Cores report completion with a
// result word. The collector retires blocks strictly in issue order. A block is
// committed only when every core in its mask has reported, which replaces the ad-hoc
// AND of per-core commit-ready flags.
// PARAMETERS
// NUM_CORES  3   number of nebula cores reporting completion
// DEPTH      8   outstanding-block table entries (power of 2, >=2)
// ID_W       8   block ID width
// RES_W      64  per-core result word width
// PORTS
// clk            in   1                  clock
// rst            in   1                  synchronous reset, active-high
// alloc_valid    in   1                  dispatcher registers a block
// alloc_ready    out  1                  table not full
// alloc_id       in   ID_W               block ID being issued
// alloc_mask     in   NUM_CORES          cores the block was sent to
// core_done      in   NUM_CORES          per-core completion pulse (1 cycle)
// core_done_id   in   NUM_CORES x ID_W   ID of the block each core finished
// core_result    in   NUM_CORES x RES_W  result word, valid with core_done
// commit_valid   out  1                  head block fully complete
// commit_ready   in   1                  IFE accepts the commit
// commit_id      out  ID_W               ID of committed block
// commit_mask    out  NUM_CORES          cores that contributed
// commit_data    out  NUM_CORES x RES_W  per-core results; lanes outside the mask are 0
// occupancy      out  $clog2(DEPTH)+1    valid entries in the table
// err_unmatched  out  1                  sticky: a done matched no expecting entry
// BEHAVIOUR
// - Reset (rst=1 at posedge): all entries invalid; head/tail/count = 0.
//   Outputs: alloc_ready=1, commit_valid=0, commit_id/mask/data=0, occupancy=0,
//   err_unmatched=0. Reset applied mid-operation discards all entries; no commit is emitted.
// - Table: ring buffer of DEPTH entries {valid, id, exp_mask, done_mask, data[NUM_CORES]}.
//   head and tail wrap modulo DEPTH.
// - Alloc: the transfer occurs when alloc_valid & alloc_ready.
//   It writes {id, exp_mask=alloc_mask, done_mask=0, data=0} at tail, then tail++.
//   alloc_ready = (count < DEPTH), computed from registered count. A commit in the
//   same cycle does not free a slot until the next cycle.
//   alloc_mask==0: accepted, no entry written, no error.
// - Done: for each core i with core_done[i], search valid entries oldest-first
//   (from head). Match the first entry with id==core_done_id[i] and exp_mask[i]=1 and
//   done_mask[i]=0. On a match, set done_mask[i] and latch core_result[i] into data[i].
//   With no match, set err_unmatched and drop the report.
//   Done is matched only against entries present before this edge; a same-cycle
//   alloc is not visible. Multiple cores reporting in one cycle are all processed.
// - Commit: commit_valid=1 while the head entry is valid and done_mask==exp_mask.
//   commit_id/mask/data are driven from the head entry and held stable until the handshake.
//   commit_valid & commit_ready -> head entry invalidated, head++.
//   The earliest commit_valid is the cycle after the last core_done edge.
// - Commit and alloc in the same cycle: count unchanged, both pointers advance.
//   Done for the head entry and commit in the same cycle: the done lands on the
//   head-entry state before invalidation, so a late done is never lost.
// - Entries complete out of order but retire only in order; a younger complete
//   entry waits behind an incomplete head.
// - occupancy = count (registered). err_unmatched is cleared only by rst.
// STRUCTURE
// - Package nebula_pkg: ID_W/RES_W defaults, typedef commit_entry_t
//   {valid, id, exp_mask, done_mask, data}, typedef core_mask_t.
// - Sub-module nebula_done_match: combinational oldest-first matcher. Given the table
//   and one core's (done, id, index), it returns a one-hot entry select and a hit flag.
//   It is instantiated NUM_CORES times via generate.
// - Top: table registers, pointers, count, commit mux, error flag.
// TESTING
// - Serial block: alloc id=0x11 mask=001; core0 done id=0x11 res=0xA5
//   -> next cycle commit_valid=1, id=0x11, mask=001, data[0]=0xA5, data[1..2]=0.
// - Parallel pair: alloc id=0x20 mask=011; core1 done at t, core0 done at t+3
//   -> commit_valid stays 0 until t+4, then carries both results.
// - Ordering: alloc 0x30 (mask=001), then 0x31 (mask=010); core1 finishes first
//   -> no commit until core0 done; 0x30 commits before 0x31.
// - Full/backpressure: 8 allocs with commit_ready=0 -> alloc_ready=0, occupancy=8.
//   A 9th alloc_valid is not accepted. After one commit, alloc_ready returns a cycle later.
// - Errors/reset: core2 done id=0x55 with no entry -> err_unmatched=1 and no state change.
//   rst pulse with 3 entries pending -> occupancy=0, commit_valid=0, err_unmatched=0.

Source files
------------

// File: rtl/nebula_pkg.sv
// Shared types for the nebula commit collector: table entry layout and core masks.
package nebula_pkg;

    localparam int NUM_CORES_DEF = 3;
    localparam int DEPTH_DEF     = 8;
    localparam int ID_W_DEF      = 8;
    localparam int RES_W_DEF     = 64;

    typedef logic [NUM_CORES_DEF-1:0] core_mask_t;

    typedef struct packed {
        logic                                    valid;
        logic [ID_W_DEF-1:0]                     id;
        core_mask_t                              exp_mask;
        core_mask_t                              done_mask;
        logic [NUM_CORES_DEF-1:0][RES_W_DEF-1:0] data;
    } commit_entry_t;

    // Matcher view of an entry, without the result payload
    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
        core_mask_t          exp_mask;
        core_mask_t          done_mask;
    } entry_tag_t;

endpackage

// File: rtl/nebula_done_match.sv
// Oldest-first search of the outstanding table for one core's completion report.
module nebula_done_match
    import nebula_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CIDX_W = (NUM_CORES_DEF > 1) ? $clog2(NUM_CORES_DEF) : 1
) (
    input  entry_tag_t [DEPTH-1:0] tags,
    input  logic [PTR_W-1:0]       head,
    input  logic                   done,
    input  logic [ID_W_DEF-1:0]    id,
    input  logic [CIDX_W-1:0]      core_idx,
    output logic [DEPTH-1:0]       sel,
    output logic                   hit
);

    logic [PTR_W-1:0] slot;

    always_comb begin
        sel  = '0;
        hit  = 1'b0;
        slot = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if (done && !hit && tags[slot].valid &&
                tags[slot].id == id &&
                tags[slot].exp_mask[core_idx] &&
                !tags[slot].done_mask[core_idx]) begin
                sel[slot] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nebula_commit_collector.sv
// In-order retirement of issued blocks once every targeted core has reported.
module nebula_commit_collector
    import nebula_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int RES_W     = RES_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [ID_W-1:0]                   alloc_id,
    input  logic [NUM_CORES-1:0]              alloc_mask,
    input  logic [NUM_CORES-1:0]              core_done,
    input  logic [NUM_CORES-1:0][ID_W-1:0]    core_done_id,
    input  logic [NUM_CORES-1:0][RES_W-1:0]   core_result,
    output logic                              commit_valid,
    input  logic                              commit_ready,
    output logic [ID_W-1:0]                   commit_id,
    output logic [NUM_CORES-1:0]              commit_mask,
    output logic [NUM_CORES-1:0][RES_W-1:0]   commit_data,
    output logic [$clog2(DEPTH):0]            occupancy,
    output logic                              err_unmatched
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CIDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    commit_entry_t [DEPTH-1:0]         tbl;
    entry_tag_t    [DEPTH-1:0]         tags;
    commit_entry_t                     head_e;
    logic [PTR_W-1:0]                  head;
    logic [PTR_W-1:0]                  tail;
    logic [CNT_W-1:0]                  count;
    logic [NUM_CORES-1:0][DEPTH-1:0]   sel;
    logic [NUM_CORES-1:0]              hit;
    logic                              do_alloc;
    logic                              do_commit;

    always_comb begin
        tags = '0;
        for (int s = 0; s < DEPTH; s++) begin
            tags[s].valid     = tbl[s].valid;
            tags[s].id        = tbl[s].id;
            tags[s].exp_mask  = tbl[s].exp_mask;
            tags[s].done_mask = tbl[s].done_mask;
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_match
        nebula_done_match #(.DEPTH(DEPTH)) u_match (
            .tags     (tags),
            .head     (head),
            .done     (core_done[c]),
            .id       (core_done_id[c]),
            .core_idx (CIDX_W'(c)),
            .sel      (sel[c]),
            .hit      (hit[c])
        );
    end

    assign head_e       = tbl[head];
    assign alloc_ready  = (count < CNT_W'(DEPTH));
    assign commit_valid = head_e.valid && (head_e.done_mask == head_e.exp_mask);
    assign commit_id    = commit_valid ? head_e.id : '0;
    assign commit_mask  = commit_valid ? head_e.exp_mask : '0;
    assign commit_data  = commit_valid ? head_e.data : '0;
    assign occupancy    = count;

    // An empty mask is accepted but leaves nothing to wait for
    assign do_alloc  = alloc_valid && alloc_ready && (alloc_mask != '0);
    assign do_commit = commit_valid && commit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl           <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            err_unmatched <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (sel[c][s]) begin
                        tbl[s].done_mask[c] <= 1'b1;
                        tbl[s].data[c]      <= core_result[c];
                    end
                end
            end
            if (do_commit) begin
                tbl[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            if (do_alloc) begin
                tbl[tail] <= '{valid: 1'b1, id: alloc_id,
                               exp_mask: alloc_mask,
                               done_mask: '0, data: '0};
                tail      <= tail + 1'b1;
            end
            count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
            if ((core_done & ~hit) != '0)
                err_unmatched <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nebula_commit_collector.sv
// Scoreboard bench for the commit collector: expected commits queued at stimulus time.
module tb_nebula_commit_collector;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [7:0]       alloc_id;
    logic [2:0]       alloc_mask;
    logic [2:0]       core_done;
    logic [2:0][7:0]  core_done_id;
    logic [2:0][63:0] core_result;
    logic             commit_valid;
    logic             commit_ready;
    logic [7:0]       commit_id;
    logic [2:0]       commit_mask;
    logic [2:0][63:0] commit_data;
    logic [3:0]       occupancy;
    logic             err_unmatched;

    typedef struct {
        logic [7:0]       id;
        logic [2:0]       mask;
        logic [2:0][63:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    nebula_commit_collector dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_id      (alloc_id),
        .alloc_mask    (alloc_mask),
        .core_done     (core_done),
        .core_done_id  (core_done_id),
        .core_result   (core_result),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_id     (commit_id),
        .commit_mask   (commit_mask),
        .commit_data   (commit_data),
        .occupancy     (occupancy),
        .err_unmatched (err_unmatched)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(logic [7:0] id, logic [2:0] mask);
        alloc_valid = 1'b1;
        alloc_id    = id;
        alloc_mask  = mask;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic done1(int c, logic [7:0] id, logic [63:0] r);
        core_done       = '0;
        core_done[c]    = 1'b1;
        core_done_id[c] = id;
        core_result[c]  = r;
        tick();
        core_done = '0;
    endtask

    task automatic push(logic [7:0] id, logic [2:0] mask,
                        logic [63:0] d0, logic [63:0] d1, logic [63:0] d2);
        exp_t e;
        e.id      = id;
        e.mask    = mask;
        e.data[0] = d0;
        e.data[1] = d1;
        e.data[2] = d2;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && commit_valid && commit_ready) begin
            if (q.size() == 0) begin
                check("sb_unexpected_commit", {56'd0, commit_id}, 64'hFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("commit_id", {56'd0, commit_id}, {56'd0, e.id});
                check("commit_mask", {61'd0, commit_mask}, {61'd0, e.mask});
                for (int l = 0; l < 3; l++)
                    check($sformatf("commit_data%0d", l), commit_data[l], e.data[l]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        alloc_valid  = 1'b0;
        alloc_id     = '0;
        alloc_mask   = '0;
        core_done    = '0;
        core_done_id = '0;
        core_result  = '0;
        commit_ready = 1'b1;
        tick();
        tick();
        check("rst_ar", {63'd0, alloc_ready}, 64'd1);
        check("rst_cv", {63'd0, commit_valid}, 64'd0);
        check("rst_occ", {60'd0, occupancy}, 64'd0);
        check("rst_err", {63'd0, err_unmatched}, 64'd0);
        check("rst_cid", {56'd0, commit_id}, 64'd0);
        rst = 1'b0;
        tick();

        // serial block
        alloc(8'h11, 3'b001);
        push(8'h11, 3'b001, 64'hA5, 64'h0, 64'h0);
        check("ser_cv_pre", {63'd0, commit_valid}, 64'd0);
        done1(0, 8'h11, 64'hA5);
        check("ser_cv", {63'd0, commit_valid}, 64'd1);
        tick();
        check("ser_occ", {60'd0, occupancy}, 64'd0);

        // parallel pair
        alloc(8'h20, 3'b011);
        push(8'h20, 3'b011, 64'hB0, 64'hB1, 64'h0);
        done1(1, 8'h20, 64'hB1);
        check("par_cv_t1", {63'd0, commit_valid}, 64'd0);
        tick();
        check("par_cv_t2", {63'd0, commit_valid}, 64'd0);
        tick();
        check("par_cv_t3", {63'd0, commit_valid}, 64'd0);
        done1(0, 8'h20, 64'hB0);
        check("par_cv_t4", {63'd0, commit_valid}, 64'd1);
        tick();

        // in-order retirement
        alloc(8'h30, 3'b001);
        alloc(8'h31, 3'b010);
        push(8'h30, 3'b001, 64'hC30, 64'h0, 64'h0);
        push(8'h31, 3'b010, 64'h0, 64'hC31, 64'h0);
        done1(1, 8'h31, 64'hC31);
        check("ord_cv_wait", {63'd0, commit_valid}, 64'd0);
        tick();
        check("ord_cv_wait2", {63'd0, commit_valid}, 64'd0);
        done1(0, 8'h30, 64'hC30);
        check("ord_head_id", {56'd0, commit_id}, 64'h30);
        tick();
        check("ord_next_id", {56'd0, commit_id}, 64'h31);
        tick();
        check("ord_occ", {60'd0, occupancy}, 64'd0);

        // all cores in one cycle
        alloc(8'h60, 3'b111);
        push(8'h60, 3'b111, 64'hE0, 64'hE1, 64'hE2);
        core_done    = 3'b111;
        core_done_id = {8'h60, 8'h60, 8'h60};
        core_result  = {64'hE2, 64'hE1, 64'hE0};
        tick();
        core_done = '0;
        check("multi_cv", {63'd0, commit_valid}, 64'd1);
        tick();

        // empty mask accepted without an entry
        alloc(8'h77, 3'b000);
        check("zmask_occ", {60'd0, occupancy}, 64'd0);
        check("zmask_err", {63'd0, err_unmatched}, 64'd0);

        // full table and backpressure
        commit_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            alloc(8'h40 + 8'(i), 3'b100);
        check("full_ar", {63'd0, alloc_ready}, 64'd0);
        check("full_occ", {60'd0, occupancy}, 64'd8);
        alloc(8'h99, 3'b001);
        check("full_9th_occ", {60'd0, occupancy}, 64'd8);
        push(8'h40, 3'b100, 64'h0, 64'h0, 64'hD0);
        done1(2, 8'h40, 64'hD0);
        check("full_cv", {63'd0, commit_valid}, 64'd1);
        commit_ready = 1'b1;
        check("full_ar_same", {63'd0, alloc_ready}, 64'd0);
        tick();
        check("full_ar_after", {63'd0, alloc_ready}, 64'd1);
        check("full_occ_after", {60'd0, occupancy}, 64'd7);
        for (int i = 1; i < 8; i++) begin
            push(8'h40 + 8'(i), 3'b100, 64'h0, 64'h0, 64'hD0 + 64'(i));
            done1(2, 8'h40 + 8'(i), 64'hD0 + 64'(i));
        end
        tick();
        tick();
        check("drain_occ", {60'd0, occupancy}, 64'd0);
        check("drain_err", {63'd0, err_unmatched}, 64'd0);

        // unmatched report, then reset with entries pending
        done1(2, 8'h55, 64'hFF);
        check("err_set", {63'd0, err_unmatched}, 64'd1);
        check("err_occ", {60'd0, occupancy}, 64'd0);
        check("err_cv", {63'd0, commit_valid}, 64'd0);
        alloc(8'h70, 3'b001);
        alloc(8'h71, 3'b001);
        alloc(8'h72, 3'b001);
        check("pend_occ", {60'd0, occupancy}, 64'd3);
        check("err_sticky", {63'd0, err_unmatched}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_occ", {60'd0, occupancy}, 64'd0);
        check("rst2_cv", {63'd0, commit_valid}, 64'd0);
        check("rst2_err", {63'd0, err_unmatched}, 64'd0);
        check("rst2_ar", {63'd0, alloc_ready}, 64'd1);
        tick();
        tick();
        check("sb_left", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
